// File: rtl/tx_arb_pkg.sv
// Shared types and frame constants for the transmit-side link scheduler.
package tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int BITS_PER_BYTE   = 10;
  localparam int BYTES_PER_FRAME = 2;
  localparam int MAX_REQ         = 8;
  localparam int WORD_W          = 16;

endpackage

// File: rtl/tx_arb_pick.sv
// Combinational winner picker. Round-robin starting after `last` by default;
// defining TX_ARB_FIXED_PRIO_EN makes the lowest asserted index always win.
module tx_arb_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               any,
  output logic [IDW-1:0]     win
);

  assign any = |req;

`ifdef TX_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = IDW'(k);
    end
  end
`else
  // Search last+1 upward, wrapping, so the previous winner has lowest priority.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/tx_arb.sv
// Shares the 16-bit transceiver input between requesters, one frame at a time,
// using a guard counter in place of a completion flag. Macro: TX_ARB_FIXED_PRIO_EN.
module tx_arb
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BAUD_DIV   = 2604,
  parameter int GAP_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [WORD_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [WORD_W-1:0]           tx_data,
  output logic                        trmt,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int FRAME_CYC = BITS_PER_BYTE * BYTES_PER_FRAME * BAUD_DIV + GAP_CYCLES;
  localparam int CNT_W     = $clog2(FRAME_CYC);
  localparam int IDW       = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                trmt_q, trmt_d;
  logic                busy_q, busy_d;

  logic                any;
  logic [IDW-1:0]      win;
  logic [WORD_W-1:0]   word_sel;
  logic [NUM_REQ-1:0]  win_onehot;

  tx_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .any  (any),
    .win  (win)
  );

  always_comb begin
    word_sel   = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        word_sel      = req_data[WORD_W*i +: WORD_W];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    gid_d     = gid_q;
    ack_d     = '0;
    trmt_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d   = WAIT;
          cnt_d     = CNT_W'(FRAME_CYC - 1);
          tx_data_d = word_sel;
          gid_d     = win;
          ack_d     = win_onehot;
          trmt_d    = 1'b1;
`ifndef TX_ARB_FIXED_PRIO_EN
          last_d    = win;
`endif
        end
      end
      WAIT: begin
        // Requests are ignored here; the transceiver is still shifting.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      tx_data_q <= '0;
      gid_q     <= '0;
      ack_q     <= '0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      gid_q     <= gid_d;
      ack_q     <= ack_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign trmt     = trmt_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tx_arb.sv
// Scoreboard bench for tx_arb: stimulus queues expected grants, a monitor
// checks each trmt launch against them.
module tb_tx_arb;

  localparam int NUM_REQ   = 4;
  localparam int FRAME_CYC = 82;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [15:0]          tx_data;
  logic                 trmt;
  logic [1:0]           grant_id;
  logic                 busy;

  typedef struct {
    int          id;
    logic [15:0] data;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  tx_arb #(
    .NUM_REQ    (4),
    .BAUD_DIV   (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .trmt     (trmt),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    req_data[16*i +: 16] = v;
  endtask

  task automatic push(input int id, input logic [15:0] d, input longint c);
    exp_t e;
    e.id = id; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  // Monitor: every launch must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (trmt === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_trmt", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("grant_id", longint'(grant_id), longint'(e.id));
        chk("ack", longint'(ack), longint'(1) << e.id);
        chk("tx_data", longint'(tx_data), longint'(e.data));
        chk("trmt_cycle", cyc, e.cyc);
      end
    end else begin
      chk("ack_without_trmt", longint'(ack), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0, c;
    int     n;
    rst = 1'b1;
    req = 4'b1111;
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'h1000 + 16'(i));

    // Reset held two cycles with all requesting.
    repeat (2) begin
      @(negedge clk);
      chk("rst_trmt", trmt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
    end
    t0 = cyc + 1;
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) push(0, 16'h1000, t0 + 83*k);
`else
    for (int k = 0; k < 5; k++) push(k % 4, 16'h1000 + 16'(k % 4), t0 + 83*k);
`endif
    rst = 1'b0;
    while (cyc < t0 + 332 + 5) @(negedge clk);
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Single request on requester 2.
    set_data(2, 16'hA55A);
    req = 4'b0100;
    push(2, 16'hA55A, cyc + 1);
    @(negedge clk);
    req = '0;
    set_data(2, 16'hFFFF);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, FRAME_CYC);
    repeat (5) @(negedge clk);
    chk("tx_data_hold", tx_data, 16'hA55A);

    // Request on 1 raised and dropped entirely inside a frame.
    set_data(3, 16'h3333);
    req = 4'b1000;
    push(3, 16'h3333, cyc + 1);
    @(negedge clk);
    req = '0;
    repeat (20) @(negedge clk);
    set_data(1, 16'h1111);
    req = 4'b0010;
    repeat (30) @(negedge clk);
    req = '0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("midwait_grant_id", grant_id, 3);
    chk("midwait_busy", busy, 0);

    // Reset pulsed 40 cycles into a frame while requester 3 waits.
    set_data(0, 16'h0BEE);
    req = 4'b0001;
    push(0, 16'h0BEE, cyc + 1);
    @(negedge clk);
    set_data(3, 16'h3C3C);
    req = 4'b1000;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_trmt", trmt, 0);
    chk("midrst_grant_id", grant_id, 0);
    rst = 1'b0;
    push(3, 16'h3C3C, cyc + 1);
    @(negedge clk);
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);

    // One requester streaming two words back to back.
    set_data(0, 16'h1234);
    req = 4'b0001;
    c = cyc;
    push(0, 16'h1234, c + 1);
    push(0, 16'h5678, c + 84);
    @(negedge clk);
    set_data(0, 16'h5678);
    repeat (40) @(negedge clk);
    chk("stream_hold_mid", tx_data, 16'h1234);
    while (cyc < c + 83) @(negedge clk);
    chk("stream_hold_end", tx_data, 16'h1234);
    @(negedge clk);
    req = '0;
    wait_idle();
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arb.md
# tx_arb

Transmit-side scheduler for the serial command link: it shares the single 16-bit response path (`tx_data`/`trmt` of the serial transceiver) between up to eight on-chip requesters. It grants one pending 16-bit word at a time, launches it with a one-cycle `trmt`, and holds `tx_data` stable while the two-byte frame shifts out. The transceiver exposes no completion flag, so the block blocks further grants with a frame-length guard counter. It sits between the measurement/status producers and the serial link wrapper.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `BAUD_DIV`, 2604, clocks per serial bit; must match the transceiver.
- `GAP_CYCLES`, 16, idle guard cycles added after each frame.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_data`  in  16*NUM_REQ  word of requester i on bits [16i+15:16i].
- `ack`  out  NUM_REQ  one-cycle grant pulse to the winning requester.
- `tx_data`  out  16  word to the transceiver; high byte is sent first.
- `trmt`  out  1  one-cycle launch pulse to the transceiver.
- `grant_id`  out  $clog2(NUM_REQ)  index of the most recent grant.
- `busy`  out  1  high while a frame is in flight.

## Operation
- Frame length: FRAME_CYC = 2*10*BAUD_DIV + GAP_CYCLES. This is 2 bytes of 10 bits each (start, 8 data, stop). The down-counter is $clog2(FRAME_CYC) bits wide.
- The FSM has two states, IDLE and WAIT.
- IDLE, no `req` bit set: the FSM stays in IDLE.
- IDLE, any `req` bit set:
  - Pick the winner w.
  - Register `tx_data` = `req_data[w]` and `grant_id` = w.
  - Pulse `trmt` and `ack[w]`.
  - Load the counter with FRAME_CYC-1 and go to WAIT.
- WAIT: the counter decrements each cycle. When the counter is 0, the FSM returns to IDLE. `req` is ignored throughout WAIT.
- Round-robin selection: search from `last+1` upward, wrapping at NUM_REQ-1 to 0. `last` is updated to w on each grant. At reset, `last` = NUM_REQ-1, so requester 0 has priority first.
- Requester contract:
  - Hold `req` and `req_data` stable until `ack`.
  - If `req` is still high in the cycle after `ack`, it is a new request for another word.
  - `req_data` is not sampled outside the grant cycle.
- `tx_data` holds its value from grant until the next grant. It is never cleared between frames, because the transceiver reads the high byte live from `tx_data`.
- `busy` = (state == WAIT).
- Reset values:
  - state IDLE, counter 0.
  - `tx_data` 0x0000, `trmt` 0, `ack` all 0, `grant_id` 0, `busy` 0.
  - `last` NUM_REQ-1.
- Reset mid-frame: the block returns to IDLE immediately and any in-flight word is abandoned. The system reset also resets the transceiver, so no stale frame survives.
- Simultaneous requests: exactly one `ack` bit is set per grant, never more than one.

## Timing
- `req` is seen high in IDLE at cycle C. `trmt`, `ack[w]`, `tx_data` and `grant_id` are all valid at cycle C+1, and `busy` rises at C+1.
- `busy` falls at C+1+FRAME_CYC. The earliest next `trmt` is at C+2+FRAME_CYC. Back-to-back launch spacing is therefore FRAME_CYC+1 cycles.
- All outputs are registered. There are no combinational paths from `req` to any output.

## Configuration
- `TX_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest asserted index always wins and `last` is not maintained.
- `TX_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.
- Timing and the handshake are identical in both builds.

## Structure
- Package `tx_arb_pkg` holds:
  - the state enum (`IDLE`, `WAIT`);
  - `BITS_PER_BYTE` = 10;
  - `BYTES_PER_FRAME` = 2;
  - `MAX_REQ` = 8.
- Sub-module `tx_arb_pick` is the combinational winner picker. Inputs: `req`, `last`. Outputs: `any`, `win`. The macro selects its behaviour.
- FSM, counter and output registers live in `tx_arb`.

## Test plan
Use NUM_REQ=4, BAUD_DIV=4, GAP_CYCLES=2, giving FRAME_CYC=82.
- Reset check: assert `rst` for 2 cycles with `req`=4'b1111. All outputs are 0 during reset, and the first `trmt` comes 1 cycle after `rst` drops, with `grant_id`=0.
- Single request: `req[2]` high with data 0xA55A. Next cycle: `trmt`=1, `ack`=4'b0100, `tx_data`=0xA55A. `busy` stays high for exactly 82 cycles, and `tx_data` holds 0xA55A afterward.
- All four requesting continuously: grants occur in order 0,1,2,3,0 with `trmt` spacing of exactly 83 cycles. With `TX_ARB_FIXED_PRIO_EN` defined, every grant goes to 0.
- `req[1]` raised mid-WAIT, then dropped before the frame ends: no grant to 1, and no `trmt` in WAIT.
- `rst` pulsed at cycle 40 of a frame: the next cycle shows `busy`=0 and `tx_data`=0. A pending `req[3]` is granted 1 cycle after `rst` deasserts.
- Requester keeps `req[0]` high with data 0x1234 then 0x5678 while it is the only requester: two grants 83 cycles apart, and `tx_data` changes only at the second `trmt`.
